// File: rtl/master_port_sp.sv
// rtl/master_port_sp.sv - initiator-side bus port with split and timeout handling
//
// Accepts one read/write request at a time from a local device, arbitrates for
// the bus, drives mode/addr/wdata/valid and completes on the slave's ready pulse.
// A split pulse releases the bus; the port then waits for the slave's regranted
// ready. Returns read data or a timeout error to the device.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req_valid/req_ready             device request handshake (ready only in IDLE)
//   req_mode/req_addr/req_wdata     device request fields (1 = write)
//   resp_valid/resp_err/resp_rdata  one-cycle completion pulse, timeout flag, read data
//   bus_req/bus_grant               arbiter request and grant
//   mode/addr/wdata/valid           bus transfer, qualified by valid
//   rdata/ready/split               slave read data, completion pulse, split pulse
module master_port_sp #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_mode,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              bus_req,
    input  logic              bus_grant,
    output logic              mode,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    output logic              valid,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready,
    input  logic              split
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_XFER,
        S_SPLIT_WAIT,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] count;
    logic             timeout_hit;
    logic             accept;

    // The counter first reaches CNT_LAST in the cycle the timeout is due; the
    // >= form also keeps the port from hanging if a split lands on that cycle.
    assign timeout_hit = (TIMEOUT > 0) && (count >= CNT_LAST);
    assign accept      = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (accept) state_n = S_REQ;
            end
            S_REQ: begin
                if (bus_grant) state_n = S_XFER;
            end
            S_XFER: begin
                if (ready)            state_n = S_DONE;
                else if (split)       state_n = S_SPLIT_WAIT;
                else if (timeout_hit) state_n = S_DONE;
            end
            S_SPLIT_WAIT: begin
                if (ready || timeout_hit) state_n = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            bus_req    <= 1'b0;
            mode       <= 1'b0;
            addr       <= '0;
            wdata      <= '0;
            valid      <= 1'b0;
            count      <= '0;
        end else begin
            // req_ready is registered, so it stays low for the first cycle
            // after reset release and follows IDLE from then on.
            req_ready  <= (state_n == S_IDLE);
            resp_valid <= (state_n == S_DONE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mode    <= req_mode;
                        addr    <= req_addr;
                        wdata   <= req_wdata;
                        bus_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (bus_grant) begin
                        valid <= 1'b1;
                        count <= '0;
                    end
                end
                S_XFER, S_SPLIT_WAIT: begin
                    if (count != CNT_MAX) count <= count + 1'b1;
                    if (ready) begin
                        if (!mode) resp_rdata <= rdata;
                        resp_err <= 1'b0;
                        valid    <= 1'b0;
                        bus_req  <= 1'b0;
                    end else if (split && state == S_XFER) begin
                        valid   <= 1'b0;
                        bus_req <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_err <= 1'b1;
                        valid    <= 1'b0;
                        bus_req  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
